// File: rtl/cu_pkg.sv
// Shared types and instruction field layout for the multi-cycle control unit.
package cu_pkg;

  typedef enum logic [4:0] {
    S_IDLE       = 5'b00001,
    S_DECODE     = 5'b00010,
    S_EXECUTE    = 5'b00100,
    S_MEM_ACCESS = 5'b01000,
    S_WRITE_BACK = 5'b10000
  } cu_state_e;

  typedef enum logic [1:0] {
    T_NOP   = 2'b00,
    T_ALU   = 2'b01,
    T_LOAD  = 2'b10,
    T_STORE = 2'b11
  } instr_type_e;

  localparam logic [3:0] OPCODE_RESET = 4'b1111;
  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned TYPE_W   = 2;

  // Instruction is {type, rd, rs1, rs2, offset, opcode}, MSB first.
  function automatic int unsigned opcode_lsb();
    return 0;
  endfunction

  function automatic int unsigned offset_lsb();
    return OPCODE_W;
  endfunction

  function automatic int unsigned rs2_lsb(input int unsigned dw);
    return OPCODE_W + dw;
  endfunction

  function automatic int unsigned rs1_lsb(input int unsigned dw, input int unsigned rab);
    return OPCODE_W + dw + rab;
  endfunction

  function automatic int unsigned rd_lsb(input int unsigned dw, input int unsigned rab);
    return OPCODE_W + dw + 2 * rab;
  endfunction

  function automatic int unsigned type_lsb(input int unsigned dw, input int unsigned rab);
    return OPCODE_W + dw + 3 * rab;
  endfunction

endpackage

// File: rtl/cu_regfile.sv
// Register file: two operand read ports, a debug read port and one write port.
module cu_regfile
  import cu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned REG_ADDR_BITS = 2,
  parameter int unsigned ZERO_REG      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_ADDR_BITS-1:0] raddr1,
  output logic [DATA_WIDTH-1:0]    rdata1,
  input  logic [REG_ADDR_BITS-1:0] raddr2,
  output logic [DATA_WIDTH-1:0]    rdata2,
  input  logic [REG_ADDR_BITS-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]    dbg_data,
  input  logic                     we,
  input  logic [REG_ADDR_BITS-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_BITS;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wr_blocked;

  assign wr_blocked = (ZERO_REG != 0) && (waddr == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= DATA_WIDTH'(i);
      end
    end else if (we && !wr_blocked) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1   = ((ZERO_REG != 0) && (raddr1 == '0))   ? '0 : regs[raddr1];
  assign rdata2   = ((ZERO_REG != 0) && (raddr2 == '0))   ? '0 : regs[raddr2];
  assign dbg_data = ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/cu_multicycle.sv
// Multi-cycle control unit sequencing NOP/ALU/load/store over a parametrised register file.
module cu_multicycle
  import cu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned REG_ADDR_BITS = 2,
  localparam int unsigned INSTR_WIDTH  = 2 + 3 * REG_ADDR_BITS + DATA_WIDTH + 4,
  parameter int unsigned MEM_TIMEOUT   = 16,
  parameter int unsigned ZERO_REG      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INSTR_WIDTH-1:0]   instr,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [DATA_WIDTH-1:0]    result2,
  input  logic                     mem_ready,
  output logic [DATA_WIDTH-1:0]    operand1,
  output logic [DATA_WIDTH-1:0]    operand2,
  output logic [DATA_WIDTH-1:0]    offset,
  output logic [3:0]               opcode,
  output logic                     sel1,
  output logic                     sel3,
  output logic                     w_r,
  output logic                     retire,
  output logic                     mem_err,
  output logic                     busy,
  input  logic [REG_ADDR_BITS-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]    dbg_data
);

  localparam int unsigned OPC_LSB  = opcode_lsb();
  localparam int unsigned OFF_LSB  = offset_lsb();
  localparam int unsigned RS2_LSB  = rs2_lsb(DATA_WIDTH);
  localparam int unsigned RS1_LSB  = rs1_lsb(DATA_WIDTH, REG_ADDR_BITS);
  localparam int unsigned RD_LSB   = rd_lsb(DATA_WIDTH, REG_ADDR_BITS);
  localparam int unsigned TYPE_LSB = type_lsb(DATA_WIDTH, REG_ADDR_BITS);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  cu_state_e              state, state_nxt;
  logic [INSTR_WIDTH-1:0] ir, ir_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]  operand1_nxt, operand2_nxt, offset_nxt;
  logic [3:0]             opcode_nxt;
  logic                   sel1_nxt, sel3_nxt, w_r_nxt, retire_nxt, mem_err_nxt;

  instr_type_e             ir_type;
  logic [REG_ADDR_BITS-1:0] ir_rd, ir_rs1, ir_rs2;
  logic [REG_ADDR_BITS-1:0] rf_raddr2;
  logic [DATA_WIDTH-1:0]    rf_rdata1, rf_rdata2;
  logic                     rf_we;

  assign ir_type = instr_type_e'(ir[TYPE_LSB +: TYPE_W]);
  assign ir_rd   = ir[RD_LSB  +: REG_ADDR_BITS];
  assign ir_rs1  = ir[RS1_LSB +: REG_ADDR_BITS];
  assign ir_rs2  = ir[RS2_LSB +: REG_ADDR_BITS];

  // Load/store use rd as the second operand (store data / base pairing).
  assign rf_raddr2 = (ir_type == T_ALU) ? ir_rs2 : ir_rd;

  assign busy = (state != S_IDLE);

  cu_regfile #(
    .DATA_WIDTH   (DATA_WIDTH),
    .REG_ADDR_BITS(REG_ADDR_BITS),
    .ZERO_REG     (ZERO_REG)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr1  (ir_rs1),
    .rdata1  (rf_rdata1),
    .raddr2  (rf_raddr2),
    .rdata2  (rf_rdata2),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .we      (rf_we),
    .waddr   (ir_rd),
    .wdata   (result2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      ir       <= '0;
      cnt      <= '0;
      operand1 <= '0;
      operand2 <= '0;
      offset   <= '0;
      opcode   <= OPCODE_RESET;
      sel1     <= 1'b0;
      sel3     <= 1'b0;
      w_r      <= 1'b0;
      retire   <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ir       <= ir_nxt;
      cnt      <= cnt_nxt;
      operand1 <= operand1_nxt;
      operand2 <= operand2_nxt;
      offset   <= offset_nxt;
      opcode   <= opcode_nxt;
      sel1     <= sel1_nxt;
      sel3     <= sel3_nxt;
      w_r      <= w_r_nxt;
      retire   <= retire_nxt;
      mem_err  <= mem_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ir_nxt       = ir;
    cnt_nxt      = cnt;
    operand1_nxt = operand1;
    operand2_nxt = operand2;
    offset_nxt   = offset;
    opcode_nxt   = opcode;
    sel1_nxt     = sel1;
    sel3_nxt     = sel3;
    w_r_nxt      = w_r;
    retire_nxt   = 1'b0;
    mem_err_nxt  = mem_err;
    rf_we        = 1'b0;
    instr_ready  = 1'b0;

    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        w_r_nxt     = 1'b0;
        if (instr_valid) begin
          ir_nxt = instr;
          if (instr[TYPE_LSB +: TYPE_W] == T_NOP) begin
            retire_nxt = 1'b1;
          end else begin
            state_nxt = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        operand1_nxt = rf_rdata1;
        operand2_nxt = rf_rdata2;
        offset_nxt   = ir[OFF_LSB +: DATA_WIDTH];
        opcode_nxt   = ir[OPC_LSB +: 4];
        sel1_nxt     = (ir_type == T_ALU);
        sel3_nxt     = (ir_type != T_ALU);
        state_nxt    = S_EXECUTE;
      end
      S_EXECUTE: begin
        cnt_nxt = '0;
        if (ir_type == T_ALU) begin
          state_nxt = S_WRITE_BACK;
        end else begin
          w_r_nxt   = (ir_type == T_STORE);
          state_nxt = S_MEM_ACCESS;
        end
      end
      S_MEM_ACCESS: begin
        // A completion on the final allowed cycle wins over the timeout.
        if (mem_ready) begin
          if (ir_type == T_STORE) begin
            w_r_nxt    = 1'b0;
            retire_nxt = 1'b1;
            state_nxt  = S_IDLE;
          end else begin
            state_nxt = S_WRITE_BACK;
          end
        end else if ((MEM_TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          w_r_nxt     = 1'b0;
          mem_err_nxt = 1'b1;
          state_nxt   = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_WRITE_BACK: begin
        rf_we      = 1'b1;
        retire_nxt = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: begin
        w_r_nxt   = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
